// File: rtl/lenet_frame_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// lenet_frame_sched : ping-pong 32x32 frame buffer and job scheduler for lenet
// Revision          : 1.0
// ----------------------------------------------------------------------------
module lenet_frame_sched #(
  parameter int DW      = 8,
  parameter int AW      = 10,
  parameter int TIMEOUT = 200000
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          abort_i,
  input  logic          pix_valid_i,
  input  logic [DW-1:0] pix_data_i,
  output logic          pix_ready_o,
  output logic          go_o,
  input  logic          cena_src_i,
  input  logic [AW-1:0] aa_src_i,
  output logic [DW-1:0] qa_src_o,
  input  logic          ready_i,
  input  logic [3:0]    digit_i,
  output logic          res_valid_o,
  output logic [3:0]    res_digit_o,
  output logic          res_err_o,
  input  logic          res_ready_i,
  output logic [15:0]   frames_done_o
);

  localparam int DEPTH = 1 << AW;
  localparam int WDW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_BUSY} bank_t;
  typedef enum logic [1:0] {S_IDLE, S_GO, S_RUN, S_RESULT} state_t;

  logic [DW-1:0]  mem_q [2*DEPTH];
  logic [DW-1:0]  qa_q;

  bank_t          bank_q [2];
  bank_t          bank_d [2];
  logic           wr_bank_q, wr_bank_d;
  logic [AW-1:0]  wr_cnt_q, wr_cnt_d;
  logic           pix_ready_q, pix_ready_d;

  state_t         state_q;
  logic           rd_bank_q;
  logic           go_q;
  logic           res_valid_q;
  logic [3:0]     res_digit_q;
  logic           res_err_q;
  logic [15:0]    frames_done_q;
  logic [WDW-1:0] wd_q;

  logic           accept_w;
  logic           take_w;
  logic           free_w;

  assign accept_w = pix_valid_i && pix_ready_q && !abort_i;
  assign take_w   = (state_q == S_GO);
  assign free_w   = (state_q == S_RESULT) && res_ready_i;

  // Writer and scheduler only ever touch banks in disjoint states, so their
  // updates never collide; abort overrides both.
  always_comb begin
    bank_d    = bank_q;
    wr_bank_d = wr_bank_q;
    wr_cnt_d  = wr_cnt_q;
    if (accept_w) begin
      if (wr_cnt_q == AW'(DEPTH - 1)) begin
        bank_d[wr_bank_q] = B_FULL;
        wr_bank_d         = ~wr_bank_q;
        wr_cnt_d          = '0;
      end else begin
        bank_d[wr_bank_q] = B_FILLING;
        wr_cnt_d          = wr_cnt_q + AW'(1);
      end
    end
    if (take_w) begin
      bank_d[rd_bank_q] = B_BUSY;
    end
    if (free_w) begin
      bank_d[rd_bank_q] = B_FREE;
    end
    if (abort_i) begin
      bank_d[0] = B_FREE;
      bank_d[1] = B_FREE;
      wr_bank_d = 1'b0;
      wr_cnt_d  = '0;
    end
    pix_ready_d = (bank_d[wr_bank_d] == B_FREE) || (bank_d[wr_bank_d] == B_FILLING);
  end

  always_ff @(posedge clk_i) begin
    if (rstn_i) begin
      bank_q[0]   <= B_FREE;
      bank_q[1]   <= B_FREE;
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      pix_ready_q <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      pix_ready_q <= pix_ready_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept_w) begin
      mem_q[{wr_bank_q, wr_cnt_q}] <= pix_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rstn_i) begin
      qa_q <= '0;
    end else if (!cena_src_i) begin
      qa_q <= mem_q[{rd_bank_q, aa_src_i}];
    end
  end

  // The watchdog counts from the go cycle, so the timeout result appears
  // exactly TIMEOUT cycles after go.
  always_ff @(posedge clk_i) begin
    if (rstn_i) begin
      state_q       <= S_IDLE;
      rd_bank_q     <= 1'b0;
      go_q          <= 1'b0;
      res_valid_q   <= 1'b0;
      res_digit_q   <= 4'h0;
      res_err_q     <= 1'b0;
      frames_done_q <= 16'h0000;
      wd_q          <= '0;
    end else if (abort_i) begin
      state_q     <= S_IDLE;
      rd_bank_q   <= 1'b0;
      go_q        <= 1'b0;
      res_valid_q <= 1'b0;
      wd_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bank_q[rd_bank_q] == B_FULL) begin
            state_q <= S_GO;
            go_q    <= 1'b1;
            wd_q    <= '0;
          end
        end
        S_GO: begin
          state_q <= S_RUN;
          go_q    <= 1'b0;
          wd_q    <= wd_q + WDW'(1);
        end
        S_RUN: begin
          if (ready_i) begin
            state_q     <= S_RESULT;
            res_valid_q <= 1'b1;
            res_digit_q <= digit_i;
            res_err_q   <= 1'b0;
          end else if (wd_q >= WDW'(TIMEOUT - 1)) begin
            state_q     <= S_RESULT;
            res_valid_q <= 1'b1;
            res_digit_q <= 4'hF;
            res_err_q   <= 1'b1;
          end else begin
            wd_q <= wd_q + WDW'(1);
          end
        end
        S_RESULT: begin
          if (res_ready_i) begin
            state_q       <= S_IDLE;
            res_valid_q   <= 1'b0;
            rd_bank_q     <= ~rd_bank_q;
            frames_done_q <= frames_done_q + 16'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          go_q    <= 1'b0;
        end
      endcase
    end
  end

  assign pix_ready_o   = pix_ready_q;
  assign go_o          = go_q;
  assign qa_src_o      = qa_q;
  assign res_valid_o   = res_valid_q;
  assign res_digit_o   = res_digit_q;
  assign res_err_o     = res_err_q;
  assign frames_done_o = frames_done_q;

endmodule
`default_nettype wire

// File: tb/tb_lenet_frame_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lenet_frame_sched : directed, table-driven bench for lenet_frame_sched
// Revision             : 1.0
// ----------------------------------------------------------------------------
module tb_lenet_frame_sched;

  localparam int DW      = 8;
  localparam int AW      = 10;
  localparam int TIMEOUT = 50;

  logic          clk = 1'b0;
  logic          rstn;
  logic          abort;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          pix_ready;
  logic          go;
  logic          cena_src;
  logic [AW-1:0] aa_src;
  logic [DW-1:0] qa_src;
  logic          ready;
  logic [3:0]    digit;
  logic          res_valid;
  logic [3:0]    res_digit;
  logic          res_err;
  logic          res_ready;
  logic [15:0]   frames_done;

  int checks   = 0;
  int failures = 0;
  int go_cnt   = 0;
  bit b_done   = 1'b0;

  typedef struct {
    logic          cena;
    logic [AW-1:0] addr;
    logic [DW-1:0] exp_qa;
  } rd_vec_t;

  rd_vec_t rd_tab [8];

  lenet_frame_sched #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .abort_i      (abort),
    .pix_valid_i  (pix_valid),
    .pix_data_i   (pix_data),
    .pix_ready_o  (pix_ready),
    .go_o         (go),
    .cena_src_i   (cena_src),
    .aa_src_i     (aa_src),
    .qa_src_o     (qa_src),
    .ready_i      (ready),
    .digit_i      (digit),
    .res_valid_o  (res_valid),
    .res_digit_o  (res_digit),
    .res_err_o    (res_err),
    .res_ready_i  (res_ready),
    .frames_done_o(frames_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (go === 1'b1) go_cnt <= go_cnt + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout actual=still_running required=finished");
    $fatal(1, "bench did not finish in time");
  end

  // Frame f, pixel i; pixel 0 low nibble doubles as the digit the lenet model returns.
  function automatic logic [DW-1:0] pix(input int f, input int i);
    return DW'(i * 7 + f * 17 + 7);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic stream_frame(input int f, input int npx);
    int n;
    for (int i = 0; i < npx; i++) begin
      n = 0;
      pix_valid = 1'b1;
      pix_data  = pix(f, i);
      while (!pix_ready && n < 5000) begin
        tick();
        n++;
      end
      if (!pix_ready) begin
        check($sformatf("px_stall_f%0d_i%0d", f, i), 32'(pix_ready), 32'd1);
        pix_valid = 1'b0;
        return;
      end
      tick();
    end
    pix_valid = 1'b0;
  endtask

  // Lenet model: on go, read pixel 0 and report its low nibble as the digit.
  task automatic lenet_job(output logic [3:0] d, output bit ok);
    int n;
    n = 0;
    d = 4'h0;
    while (!go && n < 3000) begin
      tick();
      n++;
    end
    ok = go;
    if (!ok) return;
    cena_src = 1'b0;
    aa_src   = '0;
    tick();
    cena_src = 1'b1;
    d = qa_src[3:0];
    tick();
    tick();
    ready = 1'b1;
    digit = d;
    tick();
    ready = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int n;
    n = 0;
    while (!res_valid && n < 200) begin
      tick();
      n++;
    end
    check(name, 32'(res_valid), 32'd1);
  endtask

  task automatic accept_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] d;
    logic [3:0] d3;
    logic [3:0] exp3 [3];
    bit         ok;
    bit         ok3;
    int         n;
    int         n3;
    int         base;

    rd_tab[0] = '{1'b0, 10'h21F, 8'hE0};
    rd_tab[1] = '{1'b1, 10'h000, 8'hE0};
    rd_tab[2] = '{1'b0, 10'h000, 8'h07};
    rd_tab[3] = '{1'b0, 10'h001, 8'h0E};
    rd_tab[4] = '{1'b0, 10'h023, 8'hFC};
    rd_tab[5] = '{1'b0, 10'h024, 8'h03};
    rd_tab[6] = '{1'b0, 10'h3FE, 8'hF9};
    rd_tab[7] = '{1'b1, 10'h155, 8'hF9};
    exp3[0] = 4'h7;
    exp3[1] = 4'h8;
    exp3[2] = 4'h9;

    rstn = 1'b1; abort = 1'b0; pix_valid = 1'b0; pix_data = '0;
    cena_src = 1'b1; aa_src = '0; ready = 1'b0; digit = 4'h0; res_ready = 1'b0;
    repeat (3) tick();

    check("rst_pix_ready", 32'(pix_ready), 32'd0);
    check("rst_go", 32'(go), 32'd0);
    check("rst_qa", 32'(qa_src), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_digit", 32'(res_digit), 32'd0);
    check("rst_res_err", 32'(res_err), 32'd0);
    check("rst_frames_done", 32'(frames_done), 32'd0);
    rstn = 1'b0;
    tick();
    check("rel_pix_ready", 32'(pix_ready), 32'd1);

    // Frame A: go exactly two cycles after the last pixel
    base = go_cnt;
    stream_frame(0, 1024);
    check("t1_go_early", 32'(go), 32'd0);
    check("t1_pix_ready", 32'(pix_ready), 32'd1);
    tick();
    check("t1_go_pulse", 32'(go), 32'd1);
    check("t1_pix_ready_go", 32'(pix_ready), 32'd1);
    tick();
    check("t1_go_low", 32'(go), 32'd0);
    check("t1_go_count", 32'(go_cnt - base), 32'd1);

    for (int i = 0; i < 8; i++) begin
      cena_src = rd_tab[i].cena;
      aa_src   = rd_tab[i].addr;
      tick();
      cena_src = 1'b1;
      check($sformatf("t2_rd%0d", i), 32'(qa_src), 32'(rd_tab[i].exp_qa));
    end
    ready = 1'b1; digit = 4'h7;
    tick();
    ready = 1'b0; digit = 4'h0;
    check("t2_res_valid", 32'(res_valid), 32'd1);
    check("t2_res_digit", 32'(res_digit), 32'h7);
    check("t2_res_err", 32'(res_err), 32'd0);
    tick();
    tick();
    check("t2_hold_valid", 32'(res_valid), 32'd1);
    check("t2_hold_digit", 32'(res_digit), 32'h7);
    check("t2_fd_before", 32'(frames_done), 32'd0);
    accept_result();
    check("t2_res_valid_drop", 32'(res_valid), 32'd0);
    check("t2_frames_done", 32'(frames_done), 32'd1);

    // Watchdog: lenet never answers; a ready in the go cycle is ignored
    stream_frame(3, 1024);
    n = 0;
    while (!go && n < 10) begin
      tick();
      n++;
    end
    check("t4_go", 32'(go), 32'd1);
    n = 0;
    ready = 1'b1; digit = 4'h5;
    tick();
    n++;
    ready = 1'b0; digit = 4'h0;
    while (!res_valid && n < 200) begin
      tick();
      n++;
    end
    check("t4_latency", 32'(n), 32'd50);
    check("t4_res_digit", 32'(res_digit), 32'hF);
    check("t4_res_err", 32'(res_err), 32'd1);
    check("t4_fd_before", 32'(frames_done), 32'd1);
    accept_result();
    check("t4_frames_done", 32'(frames_done), 32'd2);

    // Three frames back-to-back with the first result back-pressured
    fork
      begin
        stream_frame(0, 1024);
        stream_frame(1, 1024);
        b_done = 1'b1;
        stream_frame(2, 1024);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          lenet_job(d3, ok3);
          check($sformatf("t3_go%0d", k), 32'(ok3), 32'd1);
          wait_result($sformatf("t3_valid%0d", k));
          check($sformatf("t3_digit%0d", k), 32'(res_digit), 32'(exp3[k]));
          check($sformatf("t3_err%0d", k), 32'(res_err), 32'd0);
          if (k == 0) begin
            n3 = 0;
            while (!b_done && n3 < 3000) begin
              tick();
              n3++;
            end
            check("t3_b_done", 32'(b_done), 32'd1);
            check("t3_pix_ready_full", 32'(pix_ready), 32'd0);
            accept_result();
            check("t3_pix_ready_freed", 32'(pix_ready), 32'd1);
          end else begin
            accept_result();
          end
        end
      end
    join
    check("t3_frames_done", 32'(frames_done), 32'd5);

    // Abort mid-fill, offering a pixel in the abort cycle
    stream_frame(4, 300);
    abort = 1'b1; pix_valid = 1'b1; pix_data = 8'hAA;
    tick();
    abort = 1'b0; pix_valid = 1'b0;
    check("t5_fill_pix_ready", 32'(pix_ready), 32'd1);
    check("t5_fill_go", 32'(go), 32'd0);
    check("t5_fill_res_valid", 32'(res_valid), 32'd0);

    // Abort mid-RUN
    stream_frame(5, 1024);
    n = 0;
    while (!go && n < 10) begin
      tick();
      n++;
    end
    check("t5_run_go", 32'(go), 32'd1);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_run_go_low", 32'(go), 32'd0);
    check("t5_run_res_valid", 32'(res_valid), 32'd0);
    check("t5_run_pix_ready", 32'(pix_ready), 32'd1);
    base = go_cnt;
    repeat (60) tick();
    check("t5_no_watchdog", 32'(res_valid), 32'd0);
    check("t5_no_go", 32'(go_cnt - base), 32'd0);

    base = go_cnt;
    stream_frame(6, 1024);
    lenet_job(d, ok);
    check("t5_fresh_go", 32'(ok), 32'd1);
    wait_result("t5_fresh_valid");
    check("t5_fresh_digit", 32'(res_digit), 32'hD);
    accept_result();
    check("t5_frames_done", 32'(frames_done), 32'd6);
    repeat (20) tick();
    check("t5_one_go", 32'(go_cnt - base), 32'd1);

    // Reset while a result is pending
    stream_frame(7, 1024);
    lenet_job(d, ok);
    check("t6_go", 32'(ok), 32'd1);
    wait_result("t6_valid");
    check("t6_digit", 32'(res_digit), 32'hE);
    check("t6_qa", 32'(qa_src), 32'h7E);
    rstn = 1'b1;
    tick();
    check("t6_pix_ready", 32'(pix_ready), 32'd0);
    check("t6_go_rst", 32'(go), 32'd0);
    check("t6_qa_rst", 32'(qa_src), 32'd0);
    check("t6_res_valid_rst", 32'(res_valid), 32'd0);
    check("t6_res_digit_rst", 32'(res_digit), 32'd0);
    check("t6_res_err_rst", 32'(res_err), 32'd0);
    check("t6_frames_done_rst", 32'(frames_done), 32'd0);
    rstn = 1'b0;
    tick();
    check("t6_rel_pix_ready", 32'(pix_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
